i2c_target_regfile: RTL and testbench

// - I2C target (responder): the counterpart of the i2c host controller. Used as an on-chip target and as a bench peer.
// - Holds NumRegs x 8-bit registers. Controller sets an internal pointer, then writes or reads them sequentially.
// - Open-drain pad style: *_o tied 0; *_en_o=1 pulls the line low. Sits behind the pad mux on a shared scl/sda pair.

---
 rtl/i2c_target_regfile_if.sv | 11 +
 rtl/i2c_target_regfile.sv | 194 +++++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_regfile_if.sv
// i2c_target_regfile_if: open-drain SCL/SDA pad bundle between the target and its bus peer.
interface i2c_target_regfile_if;
   logic scl_i;
   logic scl_o;
   logic scl_en_o;
   logic sda_i;
   logic sda_o;
   logic sda_en_o;
   modport slave (input scl_i, sda_i, output scl_o, scl_en_o, sda_o, sda_en_o);
   modport master (output scl_i, sda_i, input scl_o, scl_en_o, sda_o, sda_en_o);
endinterface

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target exposing NumRegs byte registers behind an auto-incrementing pointer.
// Optional macro I2C_TARGET_GLITCH_FILT_EN adds a 3-sample majority filter on the synced lines.
module i2c_target_regfile #(
   parameter logic [6:0] TargetAddr = 7'h42,
   parameter int         NumRegs    = 16,
   parameter logic [7:0] ResetVal   = 8'h00,
   localparam int        PtrW       = $clog2(NumRegs)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   i2c_target_regfile_if.slave  bus,
   output logic [NumRegs*8-1:0] regs_o,
   output logic                 wr_pulse_o,
   output logic [PtrW-1:0]      wr_idx_o,
   output logic                 busy_o
);
   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK, S_WDATA, S_WACK, S_RDATA, S_RACK, S_IGNORE
   } state_t;
   logic [1:0]               r_scl_sync, r_sda_sync;
   logic                     r_scl_prev, r_sda_prev;
   logic                     w_scl, w_sda;
   state_t                   r_state, w_state_n;
   logic [2:0]               r_bitcnt, w_bitcnt_n;
   logic [7:0]               r_shift, w_shift_n;
   logic [PtrW-1:0]          r_ptr, w_ptr_n, w_ptr_inc;
   logic                     r_sda_en, w_sda_en_n;
   logic                     r_busy, w_busy_n;
   logic                     r_rw, w_rw_n;
   logic                     r_wr_pulse, w_wr_pulse_n;
   logic [PtrW-1:0]          r_wr_idx, w_wr_idx_n;
   logic                     w_we;
   logic [NumRegs-1:0][7:0]  r_regs;
   logic                     w_scl_rise, w_scl_fall, w_start, w_stop, w_last, w_ptr_ok;
   logic [7:0]               w_byte, w_rd_byte;
   // two-flop synchronizers, preset to the idle-high bus level
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_scl_sync <= 2'b11;
         r_sda_sync <= 2'b11;
      end else begin
         r_scl_sync <= {r_scl_sync[0], bus.scl_i};
         r_sda_sync <= {r_sda_sync[0], bus.sda_i};
      end
   end
`ifdef I2C_TARGET_GLITCH_FILT_EN
   logic [2:0] r_scl_filt, r_sda_filt;
   // 3-sample windows; the majority vote drops single-cycle pulses
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_scl_filt <= 3'b111;
         r_sda_filt <= 3'b111;
      end else begin
         r_scl_filt <= {r_scl_filt[1:0], r_scl_sync[1]};
         r_sda_filt <= {r_sda_filt[1:0], r_sda_sync[1]};
      end
   end
   assign w_scl = (r_scl_filt[0] & r_scl_filt[1]) | (r_scl_filt[0] & r_scl_filt[2]) | (r_scl_filt[1] & r_scl_filt[2]);
   assign w_sda = (r_sda_filt[0] & r_sda_filt[1]) | (r_sda_filt[0] & r_sda_filt[2]) | (r_sda_filt[1] & r_sda_filt[2]);
`else
   assign w_scl = r_scl_sync[1];
   assign w_sda = r_sda_sync[1];
`endif
   // previous conditioned levels for edge and bus-condition detection
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_scl_prev <= 1'b1;
         r_sda_prev <= 1'b1;
      end else begin
         r_scl_prev <= w_scl;
         r_sda_prev <= w_sda;
      end
   end
   assign w_scl_rise = w_scl & ~r_scl_prev;
   assign w_scl_fall = ~w_scl & r_scl_prev;
   assign w_start    = w_scl & r_sda_prev & ~w_sda;
   assign w_stop     = w_scl & ~r_sda_prev & w_sda;
   assign w_last     = w_scl_rise & (r_bitcnt == 3'd7);
   assign w_byte     = {r_shift[6:0], w_sda};
   assign w_rd_byte  = r_regs[r_ptr];
   assign w_ptr_ok   = {1'b0, w_byte} < 9'(NumRegs);
   assign w_ptr_inc  = (r_ptr == PtrW'(NumRegs - 1)) ? '0 : r_ptr + 1'b1;
   // next-state logic; the shift register moves one bit per SCL rise in every state,
   // which both receives bytes and advances the transmit bit in RDATA
   always_comb begin
      w_state_n    = r_state;
      w_bitcnt_n   = r_bitcnt;
      w_shift_n    = r_shift;
      w_ptr_n      = r_ptr;
      w_sda_en_n   = r_sda_en;
      w_busy_n     = r_busy;
      w_rw_n       = r_rw;
      w_wr_idx_n   = r_wr_idx;
      w_wr_pulse_n = 1'b0;
      w_we         = 1'b0;
      if (w_scl_rise) begin
         w_shift_n  = w_byte;
         w_bitcnt_n = r_bitcnt + 3'd1;
      end
      if (w_start) begin
         w_state_n  = S_ADDR;
         w_bitcnt_n = 3'd0;
         w_sda_en_n = 1'b0;
         w_busy_n   = 1'b1;
      end else if (w_stop) begin
         w_state_n  = S_IDLE;
         w_sda_en_n = 1'b0;
         w_busy_n   = 1'b0;
      end else begin
         unique case (r_state)
            S_ADDR:
               if (w_last) begin
                  w_rw_n    = w_byte[0];
                  w_state_n = (w_byte[7:1] == TargetAddr) ? S_ADDR_ACK : S_IGNORE;
               end
            S_PTR:
               if (w_last) begin
                  w_ptr_n   = w_ptr_ok ? w_byte[PtrW-1:0] : r_ptr;
                  w_state_n = w_ptr_ok ? S_PTR_ACK : S_IGNORE;
               end
            S_WDATA:
               if (w_last) begin
                  w_we         = 1'b1;
                  w_wr_pulse_n = 1'b1;
                  w_wr_idx_n   = r_ptr;
                  w_ptr_n      = w_ptr_inc;
                  w_state_n    = S_WACK;
               end
            S_RDATA: begin
               if (w_scl_fall) w_sda_en_n = ~r_shift[7];
               if (w_last) begin
                  w_ptr_n   = w_ptr_inc;
                  w_state_n = S_RACK;
               end
            end
            S_RACK: begin
               if (w_scl_fall) w_sda_en_n = 1'b0;
               if (w_scl_rise) begin
                  w_state_n  = w_sda ? S_IGNORE : S_RDATA;
                  w_shift_n  = w_rd_byte;
                  w_bitcnt_n = 3'd0;
               end
            end
            S_ADDR_ACK, S_PTR_ACK, S_WACK:
               if (w_scl_fall) begin
                  w_sda_en_n = ~r_sda_en;
                  if (r_sda_en) begin
                     w_bitcnt_n = 3'd0;
                     w_state_n  = (r_state != S_ADDR_ACK) ? S_WDATA : (r_rw ? S_RDATA : S_PTR);
                     if (r_state == S_ADDR_ACK && r_rw) begin
                        w_shift_n  = w_rd_byte;
                        w_sda_en_n = ~w_rd_byte[7];
                     end
                  end
               end
            default: ;
         endcase
      end
   end
   // state, datapath and register file update
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_bitcnt   <= 3'd0;
         r_shift    <= 8'h00;
         r_ptr      <= '0;
         r_sda_en   <= 1'b0;
         r_busy     <= 1'b0;
         r_rw       <= 1'b0;
         r_wr_pulse <= 1'b0;
         r_wr_idx   <= '0;
         r_regs     <= {NumRegs{ResetVal}};
      end else begin
         r_state    <= w_state_n;
         r_bitcnt   <= w_bitcnt_n;
         r_shift    <= w_shift_n;
         r_ptr      <= w_ptr_n;
         r_sda_en   <= w_sda_en_n;
         r_busy     <= w_busy_n;
         r_rw       <= w_rw_n;
         r_wr_pulse <= w_wr_pulse_n;
         r_wr_idx   <= w_wr_idx_n;
         if (w_we) r_regs[r_ptr] <= w_byte;
      end
   end
   assign bus.scl_o    = 1'b0;
   assign bus.scl_en_o = 1'b0;
   assign bus.sda_o    = 1'b0;
   assign bus.sda_en_o = r_sda_en & ~rst_i;
   assign regs_o       = r_regs;
   assign wr_pulse_o   = r_wr_pulse;
   assign wr_idx_o     = r_wr_idx;
   assign busy_o       = r_busy;
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: bit-banged I2C controller against a transaction-level register model.
module tb_i2c_target_regfile;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         h_scl = 1'b1;
   logic         h_sda = 1'b1;
   logic [127:0] regs;
   logic         wr_pulse;
   logic [3:0]   wr_idx;
   logic         busy;
   int           n_checks = 0;
   int           n_errors = 0;
   logic [7:0]   ref_regs [16];
   int           ref_ptr = 0;
   int           exp_idx [$];
   logic [7:0]   tx [$];
   int           wr_log [4096];
   int           wr_cnt = 0;
   int           wr_seen = 0;
   int           busy_rises = 0;
   int           sda_cyc = 0;
   logic         busy_d = 1'b0;
   i2c_target_regfile_if ifc ();
   assign ifc.scl_i = h_scl;
   assign ifc.sda_i = h_sda & ~ifc.sda_en_o;
   i2c_target_regfile dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .bus        (ifc),
      .regs_o     (regs),
      .wr_pulse_o (wr_pulse),
      .wr_idx_o   (wr_idx),
      .busy_o     (busy)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      busy_d <= busy;
      if (busy && !busy_d) busy_rises <= busy_rises + 1;
      if (ifc.sda_en_o) sda_cyc <= sda_cyc + 1;
      if (wr_pulse) begin
         wr_log[wr_cnt & 4095] <= 32'(wr_idx);
         wr_cnt <= wr_cnt + 1;
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic start_c();
      cyc(2); h_sda = 1'b1; cyc(6); h_scl = 1'b1; cyc(8); h_sda = 1'b0; cyc(8); h_scl = 1'b0;
   endtask
   task automatic stop_c();
      cyc(2); h_sda = 1'b0; cyc(6); h_scl = 1'b1; cyc(8); h_sda = 1'b1; cyc(8);
   endtask
   task automatic wbit(input logic b);
      cyc(2); h_sda = b; cyc(6); h_scl = 1'b1; cyc(8); h_scl = 1'b0;
   endtask
   task automatic rbit(output logic b);
      cyc(2); h_sda = 1'b1; cyc(6); h_scl = 1'b1; cyc(4); b = ifc.sda_i; cyc(4); h_scl = 1'b0;
   endtask
   task automatic wbyte(input logic [7:0] d, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) wbit(d[i]);
      rbit(b);
      ack = ~b;
   endtask
   task automatic rbyte(input logic ack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         rbit(b);
         d[i] = b;
      end
      wbit(~ack);
   endtask
   task automatic check_regs();
      for (int k = 0; k < 16; k++) check($sformatf("reg%0d", k), 32'(regs[8*k +: 8]), 32'(ref_regs[k]));
   endtask
   task automatic check_writes();
      int n;
      n = wr_cnt - wr_seen;
      check("wr_count", n, exp_idx.size());
      for (int i = 0; i < n && i < exp_idx.size(); i++) check("wr_idx", wr_log[(wr_seen + i) & 4095], exp_idx[i]);
      wr_seen = wr_cnt;
      exp_idx.delete();
   endtask
   task automatic model_write(input logic [7:0] d);
      ref_regs[ref_ptr] = d;
      exp_idx.push_back(ref_ptr);
      ref_ptr = (ref_ptr + 1) % 16;
   endtask
   task automatic txn_write(input logic [7:0] p);
      logic a;
      logic ok;
      ok = p < 8'd16;
      start_c();
      check("busy_start", 32'(busy), 1);
      wbyte(8'h84, a);
      check("waddr_ack", 32'(a), 1);
      wbyte(p, a);
      check("ptr_ack", 32'(a), 32'(ok));
      if (ok) ref_ptr = int'(p);
      foreach (tx[i]) begin
         wbyte(tx[i], a);
         check("data_ack", 32'(a), 32'(ok));
         if (ok) model_write(tx[i]);
      end
      stop_c();
      check("busy_stop", 32'(busy), 0);
      check("sda_released", 32'(ifc.sda_en_o), 0);
      check_writes();
      check_regs();
      tx.delete();
   endtask
   task automatic txn_read(input logic setp, input logic [7:0] p, input int n);
      logic a;
      logic [7:0] d;
      start_c();
      if (setp) begin
         wbyte(8'h84, a);
         check("waddr_ack", 32'(a), 1);
         wbyte(p, a);
         check("ptr_ack", 32'(a), 1);
         ref_ptr = int'(p);
         start_c();
      end
      wbyte(8'h85, a);
      check("raddr_ack", 32'(a), 1);
      for (int i = 0; i < n; i++) begin
         rbyte(i < n - 1, d);
         check("rdata", 32'(d), 32'(ref_regs[ref_ptr]));
         ref_ptr = (ref_ptr + 1) % 16;
      end
      check("sda_after_nack", 32'(ifc.sda_en_o), 0);
      stop_c();
      check("busy_stop", 32'(busy), 0);
      check_writes();
   endtask
   initial begin
      logic a;
      int s0;
      for (int k = 0; k < 16; k++) ref_regs[k] = 8'h00;
      cyc(4);
      check("rst_sda_en", 32'(ifc.sda_en_o), 0);
      check("rst_busy", 32'(busy), 0);
      rst = 1'b0;
      cyc(4);
      check("rst_wr_pulse", 32'(wr_pulse), 0);
      check("rst_wr_idx", 32'(wr_idx), 0);
      check("scl_en", 32'(ifc.scl_en_o), 0);
      check_regs();
      tx = '{8'hA5, 8'h5A};
      txn_write(8'h03);
      txn_read(1'b1, 8'h03, 2);
      txn_read(1'b0, 8'h00, 1);
      start_c();
      check("busy_wrong", 32'(busy), 1);
      s0 = sda_cyc;
      wbyte(8'h90, a);
      check("wrong_nack", 32'(a), 0);
      stop_c();
      check("wrong_no_drive", sda_cyc - s0, 0);
      check("busy_wrong_stop", 32'(busy), 0);
      check_writes();
      check_regs();
      tx = '{8'h11, 8'h22};
      txn_write(8'h0F);
      tx = '{8'h77};
      txn_write(8'h10);
      txn_read(1'b0, 8'h00, 1);
      start_c();
      wbyte(8'h84, a);
      wbyte(8'h06, a);
      for (int i = 0; i < 5; i++) wbit(1'($urandom_range(0, 1)));
      start_c();
      wbyte(8'h84, a);
      check("abort_addr_ack", 32'(a), 1);
      wbyte(8'h07, a);
      ref_ptr = 7;
      wbyte(8'h3C, a);
      check("abort_data_ack", 32'(a), 1);
      model_write(8'h3C);
      stop_c();
      check_writes();
      check_regs();
      s0 = busy_rises;
      cyc(4);
      h_sda = 1'b0;
      cyc(1);
      h_sda = 1'b1;
      cyc(12);
`ifdef I2C_TARGET_GLITCH_FILT_EN
      check("glitch_busy", busy_rises - s0, 0);
`else
      check("glitch_busy", busy_rises - s0, 1);
`endif
      check("glitch_idle", 32'(busy), 0);
      start_c();
      for (int i = 7; i >= 0; i--) wbit(i == 7 || i == 2);
      cyc(2);
      h_sda = 1'b1;
      cyc(4);
      check("ack_drive", 32'(ifc.sda_en_o), 1);
      rst = 1'b1;
      #1;
      check("rst_release", 32'(ifc.sda_en_o), 0);
      cyc(2);
      h_scl = 1'b1;
      cyc(3);
      rst = 1'b0;
      cyc(10);
      for (int k = 0; k < 16; k++) ref_regs[k] = 8'h00;
      ref_ptr = 0;
      check("rst_busy2", 32'(busy), 0);
      check_regs();
      for (int it = 0; it < 24; it++) begin
         int op;
         op = $urandom_range(0, 3);
         if (op < 2) begin
            logic [7:0] p;
            p = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            for (int i = 0; i < $urandom_range(1, 4); i++) tx.push_back(8'($urandom));
            txn_write(p);
         end else if (op == 2) begin
            txn_read(1'b1, 8'($urandom_range(0, 15)), $urandom_range(1, 4));
         end else begin
            txn_read(1'b0, 8'h00, $urandom_range(1, 3));
         end
      end
      check_regs();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
